// File: rtl/hazard_scoreboard.sv
// Load-use stall, redirect flush and registered EX forward-select control for the in-order pipeline.
// Build option: define HAZARD_FWD_EN for operand forwarding; undefined, every RAW dependency stalls.
module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int RAW      = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int SELW     = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RAW-1:0]  id_rs1,
    input  logic            id_rs1_use,
    input  logic [RAW-1:0]  id_rs2,
    input  logic            id_rs2_use,
    input  logic [RAW-1:0]  id_rd,
    input  logic            id_rd_we,
    input  logic            id_is_load,
    input  logic            ex_redirect,
    output logic            stall_if,
    output logic            bubble_id,
    output logic            flush_id,
    output logic [SELW-1:0] fwd1_sel,
    output logic [SELW-1:0] fwd2_sel,
    output logic            busy
);

    logic [DEPTH:1]  v_q, we_q, ld_q;
    logic [RAW-1:0]  rd_q [1:DEPTH];
    logic [SELW-1:0] fwd1_q, fwd1_d, fwd2_q, fwd2_d;

    logic [SELW-1:0] y1, y2;
    logic            y1_ld, y2_ld;
    logic            rs1_live, rs2_live;
    logic            haz1, haz2, advance;

    // Reg 0 and addresses outside the register file never create a dependency.
    assign rs1_live = id_rs1_use && (id_rs1 != '0) && ({1'b0, id_rs1} < (RAW+1)'(NREG));
    assign rs2_live = id_rs2_use && (id_rs2 != '0) && ({1'b0, id_rs2} < (RAW+1)'(NREG));

    // Scan oldest to youngest so the youngest matching slot is what remains.
    always_comb begin
        y1    = '0;
        y2    = '0;
        y1_ld = 1'b0;
        y2_ld = 1'b0;
        for (int s = DEPTH; s >= 1; s--) begin
            if (v_q[s] && we_q[s] && rs1_live && (rd_q[s] == id_rs1)) begin
                y1    = SELW'(s);
                y1_ld = ld_q[s];
            end
            if (v_q[s] && we_q[s] && rs2_live && (rd_q[s] == id_rs2)) begin
                y2    = SELW'(s);
                y2_ld = ld_q[s];
            end
        end
    end

`ifdef HAZARD_FWD_EN
    assign haz1 = (y1 != '0) && y1_ld && (y1 <= SELW'(LOAD_LAT));
    assign haz2 = (y2 != '0) && y2_ld && (y2 <= SELW'(LOAD_LAT));
    assign fwd1_d = advance ? y1 : '0;
    assign fwd2_d = advance ? y2 : '0;
`else
    logic unused_ld;
    assign unused_ld = y1_ld ^ y2_ld;
    assign haz1   = (y1 != '0);
    assign haz2   = (y2 != '0);
    assign fwd1_d = '0;
    assign fwd2_d = '0;
`endif

    // A redirect kills the ID instruction, so it never waits on a hazard.
    assign stall_if  = id_valid && (haz1 || haz2) && !ex_redirect;
    assign bubble_id = stall_if;
    assign flush_id  = ex_redirect;
    assign advance   = id_valid && !stall_if && !ex_redirect;
    assign busy      = |v_q;
    assign fwd1_sel  = fwd1_q;
    assign fwd2_sel  = fwd2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            we_q   <= '0;
            ld_q   <= '0;
            fwd1_q <= '0;
            fwd2_q <= '0;
            for (int s = 1; s <= DEPTH; s++) begin
                rd_q[s] <= '0;
            end
        end else begin
            for (int s = DEPTH; s >= 2; s--) begin
                v_q[s]  <= v_q[s-1];
                we_q[s] <= we_q[s-1];
                ld_q[s] <= ld_q[s-1];
                rd_q[s] <= rd_q[s-1];
            end
            v_q[1]  <= advance;
            we_q[1] <= id_rd_we;
            ld_q[1] <= id_is_load;
            rd_q[1] <= id_rd;
            fwd1_q  <= fwd1_d;
            fwd2_q  <= fwd2_d;
        end
    end

endmodule
